// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg
// Shared definitions for the WS2812B receive path (and the matching
// transmitter): FSM state encoding, default line timing at 12 MHz and
// the 24-bit GRB pixel type.
package ws2812b_pkg;

  // Receiver line-tracking states.
  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    HIGH,
    LOW
  } rx_state_e;

  // Default timing in clk cycles at 12 MHz.
  localparam int DEF_BIT_THRESH   = 7;
  localparam int DEF_MIN_HIGH     = 2;
  localparam int DEF_MAX_HIGH     = 20;
  localparam int DEF_RESET_CYCLES = 600;

  localparam int PIXEL_BITS = 24;

  // One pixel as it appears on the wire: green first, MSB first.
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_pixel_t;

endpackage

// File: rtl/ws2812b_rx_sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both stages
//   d     - asynchronous input
//   q     - synchronized output (two clk cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] stage_q;
  logic [1:0] stage_d;

  always_comb begin
    stage_d = {stage_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= 2'b00;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[1];

endmodule

// File: rtl/ws2812b_rx.sv
// ws2812b_rx
// Decodes a WS2812B serial stream into 24-bit GRB pixels with a
// valid/ready holding register.
// Ports:
//   clk         - system clock (12 MHz)
//   rst_n       - asynchronous active-low reset
//   ws2812b_in  - asynchronous serial data line
//   pixel_data  - held pixel, GRB, first wire bit in bit 23
//   pixel_valid - pixel_data holds an unconsumed pixel
//   pixel_ready - consumer accepts the pixel when high with pixel_valid
//   pixel_index - position of pixel_data within the current frame
//   frame_done  - one-cycle pulse on a detected reset gap
//   bit_err     - one-cycle pulse on a glitch or over-long high pulse
//   frame_err   - one-cycle pulse when a reset gap ends a partial pixel
//   overrun     - sticky, a completed pixel was dropped while the
//                 holding register was full
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int BIT_THRESH   = DEF_BIT_THRESH,
  parameter int MIN_HIGH     = DEF_MIN_HIGH,
  parameter int MAX_HIGH     = DEF_MAX_HIGH,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ws2812b_in,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic [5:0]  pixel_index,
  output logic        frame_done,
  output logic        bit_err,
  output logic        frame_err,
  output logic        overrun
);

  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_CYCLES + 1);

  localparam logic [HW-1:0] HIGH_ONE = HW'(1);
  localparam logic [HW-1:0] HIGH_SAT = HW'(MAX_HIGH + 1);
  localparam logic [HW-1:0] HIGH_MIN = HW'(MIN_HIGH);
  localparam logic [HW-1:0] HIGH_ONE_BIT = HW'(BIT_THRESH);
  localparam logic [LW-1:0] LOW_ONE  = LW'(1);
  localparam logic [LW-1:0] LOW_GAP  = LW'(RESET_CYCLES);
  localparam logic [4:0]    LAST_BIT = 5'(PIXEL_BITS - 1);

  logic rin;

  rx_state_e     state_q, state_d;
  logic [HW-1:0] high_cnt_q, high_cnt_d;
  logic [LW-1:0] low_cnt_q, low_cnt_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [22:0]   shift_q, shift_d;
  logic [5:0]    pix_cnt_q, pix_cnt_d;
  grb_pixel_t    pixel_data_q, pixel_data_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic [5:0]    pixel_index_q, pixel_index_d;
  logic          frame_done_q, frame_done_d;
  logic          bit_err_q, bit_err_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;

  logic bit_strobe;
  logic bit_value;
  logic gap;

  sync_2ff u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ws2812b_in),
    .q    (rin)
  );

  // Next-state logic. Being in HIGH means rin was high last cycle, so
  // rin low there is the falling edge; likewise rin high in IDLE/LOW is
  // the rising edge. low_cnt doubles as the SYNC gap counter.
  always_comb begin
    state_d       = state_q;
    high_cnt_d    = high_cnt_q;
    low_cnt_d     = low_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    pix_cnt_d     = pix_cnt_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = pixel_valid_q;
    pixel_index_d = pixel_index_q;
    frame_done_d  = 1'b0;
    bit_err_d     = 1'b0;
    frame_err_d   = 1'b0;
    overrun_d     = overrun_q;
    bit_strobe    = 1'b0;
    bit_value     = 1'b0;
    gap           = 1'b0;

    case (state_q)
      SYNC: begin
        if (rin) begin
          low_cnt_d = '0;
        end else begin
          low_cnt_d = low_cnt_q + LOW_ONE;
          if (low_cnt_d == LOW_GAP) begin
            state_d   = IDLE;
            low_cnt_d = '0;
          end
        end
      end
      IDLE: begin
        if (rin) begin
          state_d    = HIGH;
          high_cnt_d = HIGH_ONE;
        end
      end
      HIGH: begin
        if (high_cnt_q == HIGH_SAT) begin
          // Over-long pulse: the stream is no longer trusted until a
          // fresh reset gap is seen.
          bit_err_d  = 1'b1;
          state_d    = SYNC;
          high_cnt_d = '0;
          low_cnt_d  = '0;
          bit_cnt_d  = '0;
          shift_d    = '0;
        end else if (rin) begin
          high_cnt_d = high_cnt_q + HIGH_ONE;
        end else begin
          state_d   = LOW;
          low_cnt_d = LOW_ONE;
          if (high_cnt_q < HIGH_MIN) begin
            bit_err_d = 1'b1;
          end else begin
            bit_strobe = 1'b1;
            bit_value  = (high_cnt_q >= HIGH_ONE_BIT);
          end
        end
      end
      LOW: begin
        if (rin) begin
          state_d    = HIGH;
          high_cnt_d = HIGH_ONE;
        end else begin
          low_cnt_d = low_cnt_q + LOW_ONE;
          if (low_cnt_d == LOW_GAP) begin
            gap = 1'b1;
          end
        end
      end
      default: begin
        state_d = SYNC;
      end
    endcase

    if (gap) begin
      frame_done_d  = 1'b1;
      frame_err_d   = (bit_cnt_q != 5'd0);
      state_d       = IDLE;
      low_cnt_d     = '0;
      bit_cnt_d     = '0;
      shift_d       = '0;
      pix_cnt_d     = '0;
      pixel_index_d = '0;
    end

    if (pixel_valid_q && pixel_ready) begin
      pixel_valid_d = 1'b0;
    end

    // A completing pixel loads whenever the holding register is free or
    // being emptied this same cycle; otherwise it is dropped but still
    // advances the frame position.
    if (bit_strobe) begin
      shift_d = {shift_q[21:0], bit_value};
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        shift_d   = '0;
        pix_cnt_d = pix_cnt_q + 6'd1;
        if (pixel_valid_q && !pixel_ready) begin
          overrun_d = 1'b1;
        end else begin
          pixel_data_d  = grb_pixel_t'({shift_q, bit_value});
          pixel_index_d = pix_cnt_q;
          pixel_valid_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SYNC;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      pix_cnt_q     <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pixel_index_q <= '0;
      frame_done_q  <= 1'b0;
      bit_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      pix_cnt_q     <= pix_cnt_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_index_q <= pixel_index_d;
      frame_done_q  <= frame_done_d;
      bit_err_q     <= bit_err_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_index = pixel_index_q;
  assign frame_done  = frame_done_q;
  assign bit_err     = bit_err_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;

endmodule

// File: doc/ws2812b_rx.md
WS2812B_RX -- requirements
Module: ws2812b_rx

Interface
REQ-001 SHALL have parameter BIT_THRESH, default 7; high width in clk cycles at or above which a bit decodes as 1.
REQ-002 SHALL have parameter MIN_HIGH, default 2; high pulses shorter than this are glitches.
REQ-003 SHALL have parameter MAX_HIGH, default 20; high pulses longer than this are errors.
REQ-004 SHALL have parameter RESET_CYCLES, default 600; low time that marks a latch/reset gap (50 us at 12 MHz).
REQ-005 clk  input  1  system clock (12 MHz); the single clock.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 ws2812b_in  input  1  asynchronous WS2812B serial data line.
REQ-008 pixel_data  output  24  received pixel, GRB order, MSB (G[7]) first on the wire.
REQ-009 pixel_valid  output  1  pixel_data holds an unconsumed pixel.
REQ-010 pixel_ready  input  1  consumer accepts pixel when high with pixel_valid.
REQ-011 pixel_index  output  6  position of pixel_data within the current frame.
REQ-012 frame_done  output  1  one-cycle pulse on a detected reset gap.
REQ-013 bit_err  output  1  one-cycle pulse on a glitch or over-long high pulse.
REQ-014 frame_err  output  1  one-cycle pulse when a reset gap ends a partial pixel.
REQ-015 overrun  output  1  sticky; a completed pixel was dropped because the holding register was full.

Function
REQ-016 ws2812b_in SHALL pass through a two-flop synchronizer; all timing uses the synchronized signal (rin).
REQ-017 FSM states SHALL be SYNC, IDLE, HIGH, LOW.
REQ-018 SYNC: count consecutive low cycles of rin; reaching RESET_CYCLES -> IDLE; any high restarts the count; no bits are decoded.
REQ-019 IDLE/LOW: rising edge of rin -> HIGH with the high counter cleared to 1.
REQ-020 HIGH: counter saturates at MAX_HIGH+1; falling edge -> LOW and classify: width < MIN_HIGH -> bit_err and bit discarded; width >= BIT_THRESH -> 1; otherwise 0.
REQ-021 HIGH: width exceeding MAX_HIGH -> bit_err, partial pixel discarded, state SYNC.
REQ-022 LOW: low counter reaching RESET_CYCLES -> frame_done pulse, pixel_index := 0, bit count := 0, state IDLE; if bit count was nonzero, frame_err pulses in the same cycle.
REQ-023 Bits SHALL shift into a 24-bit register MSB first; a 5-bit bit counter wraps 23 -> 0.
REQ-024 On the 24th bit, the pixel SHALL load into the holding register and pixel_valid SHALL rise on the following edge (total 3 cycles after the raw falling edge at ws2812b_in).
REQ-025 If pixel_valid is high and pixel_ready is low when a pixel completes: new pixel dropped, overrun := 1, pixel_data/pixel_index unchanged.
REQ-026 If pixel_valid and pixel_ready are high in the same cycle a pixel completes, the new pixel SHALL load and pixel_valid SHALL stay high (no overrun).
REQ-027 pixel_valid SHALL clear on acceptance unless REQ-026 applies; pixel_data SHALL be stable while valid.
REQ-028 pixel_index SHALL increment per completed pixel (including dropped ones) and wrap 63 -> 0.
REQ-029 overrun SHALL clear only on reset.

Reset
REQ-030 On rst_n low: state SYNC, all counters 0, synchronizer flops 0, pixel_data 0, pixel_valid 0, pixel_index 0, frame_done/bit_err/frame_err 0, overrun 0.
REQ-031 Reset mid-pixel SHALL discard all partial data; after release, a full RESET_CYCLES low gap SHALL be required before decoding.

Structure
REQ-032 Package ws2812b_pkg SHALL hold the FSM state typedef, default timing constants, and the 24-bit GRB pixel typedef, shared with the transmitter.
REQ-033 One sub-module: sync_2ff (two-flop synchronizer with async active-low reset).

Verification
REQ-034 Reset, 600 low cycles, then 24 bits 0xFF0000 (1=10H/5L, 0=5H/10L) -> pixel_valid with pixel_data 0xFF0000, pixel_index 0.
REQ-035 Three pixels 0x123456, 0xABCDEF, 0x000001, pixel_ready held high, then 600 low -> indices 0,1,2 in order, frame_done once, no frame_err.
REQ-036 pixel_ready low across two pixels 0x111111, 0x222222 -> pixel_data stays 0x111111, overrun = 1.
REQ-037 1-cycle high glitch mid-pixel -> bit_err pulse, following 24 bits decode correctly.
REQ-038 12 bits then 600 low -> frame_done and frame_err pulse together, no pixel_valid; 25-cycle high -> bit_err, no decode until a new 600-cycle gap.
REQ-039 65 pixels in one frame -> 65th pixel has pixel_index 0 (wrap).
